// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - N-source arbiter feeding a single registered output stage
// with fixed-priority or round-robin grant selection.
module bus_arb_mux #(
  parameter int N_SRC  = 6,
  parameter int DATA_W = 32,
  parameter int MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            req,
  input  logic [N_SRC*DATA_W-1:0]     in_data,
  output logic [N_SRC-1:0]            gnt,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(N_SRC)-1:0]    out_src,
  output logic [15:0]                 xfer_cnt
);

  localparam int SW = $clog2(N_SRC);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SW-1:0]     out_src_q, out_src_d;
  logic [15:0]       xfer_cnt_q, xfer_cnt_d;
  logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]     sel;
  logic              load;
  int                idx;

  // Loops run from the lowest-precedence candidate up so the last hit wins.
  always_comb begin
    sel = '0;
    idx = 0;
    if (MODE == 0) begin
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (req[i]) sel = SW'(i);
      end
    end else begin
      for (int k = N_SRC; k >= 1; k--) begin
        idx = (int'(rr_ptr_q) + k) % N_SRC;
        if (req[idx]) sel = SW'(idx);
      end
    end
  end

  assign load = (~out_valid_q | out_ready) & (|req) & ~rst;
  assign gnt  = load ? (N_SRC'(1) << sel) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (out_valid_q && out_ready) xfer_cnt_d = xfer_cnt_q + 16'd1;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(sel)*DATA_W +: DATA_W];
      out_src_d   = sel;
      if (MODE == 1) rr_ptr_d = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // rr_ptr resets to the last index so the first round-robin search begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      xfer_cnt_q  <= '0;
      rr_ptr_q    <= SW'(N_SRC - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      xfer_cnt_q  <= xfer_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb/tb_bus_arb_mux.sv - directed checks of bus_arb_mux in fixed-priority and
// round-robin configurations.
module tb_bus_arb_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic [191:0] in_data;
  logic [5:0]   req0, req1;
  logic         rdy0, rdy1;
  logic [5:0]   gnt0, gnt1;
  logic         valid0, valid1;
  logic [31:0]  data0, data1;
  logic [2:0]   src0, src1;
  logic [15:0]  cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_arb_mux #(.N_SRC(6), .DATA_W(32), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .req(req0), .in_data(in_data), .gnt(gnt0),
    .out_valid(valid0), .out_ready(rdy0), .out_data(data0), .out_src(src0),
    .xfer_cnt(cnt0));

  bus_arb_mux #(.N_SRC(6), .DATA_W(32), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .in_data(in_data), .gnt(gnt1),
    .out_valid(valid1), .out_ready(rdy1), .out_data(data1), .out_src(src1),
    .xfer_cnt(cnt1));

  typedef struct {
    logic [5:0]  req;
    logic        rdy;
    logic [5:0]  gnt;
    logic        valid;
    logic [2:0]  src;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] chan(input int i);
    return 32'hC0DE_0000 | 32'(i * 32'h11);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) in_data[i*32 +: 32] = chan(i);
    tbl[0] = '{6'b101100, 1'b1, 6'b000100, 1'b1, 3'd2, 16'd0};
    tbl[1] = '{6'b000000, 1'b1, 6'b000000, 1'b0, 3'd2, 16'd1};
    tbl[2] = '{6'b110000, 1'b0, 6'b010000, 1'b1, 3'd4, 16'd1};
    tbl[3] = '{6'b000011, 1'b0, 6'b000000, 1'b1, 3'd4, 16'd1};
    tbl[4] = '{6'b000011, 1'b1, 6'b000001, 1'b1, 3'd0, 16'd2};
    tbl[5] = '{6'b100000, 1'b1, 6'b100000, 1'b1, 3'd5, 16'd3};
    tbl[6] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 3'd5, 16'd3};
    tbl[7] = '{6'b000000, 1'b1, 6'b000000, 1'b0, 3'd5, 16'd4};

    rst = 1'b1; req0 = '1; req1 = '1; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(gnt0), 0);
    check("rst_gnt1", 32'(gnt1), 0);
    check("rst_valid0", 32'(valid0), 0);
    check("rst_data0", data0, 0);
    check("rst_src0", 32'(src0), 0);
    check("rst_cnt0", 32'(cnt0), 0);
    @(negedge clk);
    rst = 1'b0; req0 = '0; req1 = '0;

    // Fixed priority table, each row depends on the state left by the previous one.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req0 = tbl[v].req; rdy0 = tbl[v].rdy;
      #1;
      check($sformatf("tbl%0d_gnt", v), 32'(gnt0), 32'(tbl[v].gnt));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_valid", v), 32'(valid0), 32'(tbl[v].valid));
      check($sformatf("tbl%0d_src", v), 32'(src0), 32'(tbl[v].src));
      check($sformatf("tbl%0d_cnt", v), 32'(cnt0), 32'(tbl[v].cnt));
      if (tbl[v].valid) check($sformatf("tbl%0d_data", v), data0, chan(int'(tbl[v].src)));
    end

    // Backpressure: load source 0, then stall with source 1 waiting.
    @(negedge clk);
    req0 = 6'b000001; rdy0 = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req0 = 6'b000010; rdy0 = 1'b0;
      #1;
      check($sformatf("bp%0d_gnt", c), 32'(gnt0), 0);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_src", c), 32'(src0), 0);
      check($sformatf("bp%0d_data", c), data0, chan(0));
    end
    @(negedge clk);
    rdy0 = 1'b1;
    #1;
    check("bp_release_gnt", 32'(gnt0), 32'(6'b000010));
    @(posedge clk);
    #1;
    check("bp_release_src", 32'(src0), 1);
    check("bp_release_data", data0, chan(1));
    @(negedge clk);
    req0 = '0;

    // Round-robin fairness on u1 with everyone requesting.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req1 = 6'b111111; rdy1 = 1'b1;
      #1;
      check($sformatf("rr%0d_gnt", k), 32'(gnt1), 32'(6'b000001 << (k % 6)));
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_src", k), 32'(src1), k % 6);
      check($sformatf("rr%0d_data", k), data1, chan(k % 6));
    end

    // Asynchronous reset pulse between edges while u1 holds data.
    #1;
    check("ar_pre_valid", 32'(valid1), 1);
    rst = 1'b1;
    #1;
    check("ar_valid1", 32'(valid1), 0);
    check("ar_cnt1", 32'(cnt1), 0);
    check("ar_gnt1", 32'(gnt1), 0);
    rst = 1'b0;
    @(negedge clk);
    req1 = 6'b111111; rdy1 = 1'b1; req0 = '0; rdy0 = 1'b1;
    #1;
    check("ar_first_gnt", 32'(gnt1), 32'(6'b000001));
    @(posedge clk);
    @(negedge clk);
    req1 = '0;

    // Throughput: u0 is empty with count 0 after the reset pulse.
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req0 = 6'b000001; rdy0 = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("tp%0d_valid", c), 32'(valid0), 1);
    end
    check("tp_cnt", 32'(cnt0), 9);

    repeat (65526) begin
      @(negedge clk);
      @(posedge clk);
    end
    #1;
    check("wrap_ffff", 32'(cnt0), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    check("wrap_zero", 32'(cnt0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
